comment_strip: RTL

Character-stream pre-filter placed directly upstream of the `int` declaration checker. It removes C-style comments from the ASCII stream before the checker sees it:
- `//` line comments run to the newline.
- `/* */` block comments run to the closing `*/`.
- Each comment is replaced by one space (ASCII 32), so tokens on either side stay separated.
- All other characters pass through unchanged and in order.

Input uses a valid/ready handshake. The output is a registered character with a one-cycle valid strobe.

---
 rtl/comment_strip.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/comment_strip.sv
// comment_strip: removes C-style line and block comments from an ASCII
// character stream. Each comment collapses to a single space. All other
// characters pass through in order. The output is a registered character
// qualified by a one-cycle valid strobe.
module comment_strip #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             out_valid,
  output logic             in_comment,
  output logic [CNT_W-1:0] comment_cnt
);

  localparam logic [7:0] CH_SLASH = 8'd47;
  localparam logic [7:0] CH_STAR  = 8'd42;
  localparam logic [7:0] CH_NL    = 8'd10;
  localparam logic [7:0] CH_SP    = 8'd32;

  typedef enum logic [2:0] {
    NORM  = 3'd0,
    SLASH = 3'd1,
    PEND  = 3'd2,
    LINE  = 3'd3,
    BLOCK = 3'd4,
    BSTAR = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pend;
  logic [7:0] pend_nxt;
  logic       emit;
  logic [7:0] emit_chr;
  logic       open_cmt;
  logic       accept;

  // PEND spends its cycle replaying the stored character, so input stalls
  assign in_ready   = (state != PEND);
  assign accept     = in_valid && in_ready;
  assign in_comment = (state == LINE) || (state == BLOCK) || (state == BSTAR);

  // Next-state, emitted character and comment-open decode
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    emit      = 1'b0;
    emit_chr  = in;
    open_cmt  = 1'b0;
    case (state)
      NORM: begin
        if (accept) begin
          if (in == CH_SLASH) begin
            state_nxt = SLASH;
          end else begin
            emit = 1'b1;
          end
        end
      end
      SLASH: begin
        if (accept) begin
          if (in == CH_SLASH) begin
            state_nxt = LINE;
            emit      = 1'b1;
            emit_chr  = CH_SP;
            open_cmt  = 1'b1;
          end else if (in == CH_STAR) begin
            state_nxt = BLOCK;
            emit      = 1'b1;
            emit_chr  = CH_SP;
            open_cmt  = 1'b1;
          end else begin
            // the held slash was ordinary text: release it now, the new
            // character follows one cycle later
            state_nxt = PEND;
            emit      = 1'b1;
            emit_chr  = CH_SLASH;
            pend_nxt  = in;
          end
        end
      end
      PEND: begin
        if (pend == CH_SLASH) begin
          state_nxt = SLASH;
        end else begin
          state_nxt = NORM;
          emit      = 1'b1;
          emit_chr  = pend;
        end
      end
      LINE: begin
        if (accept && (in == CH_NL)) begin
          state_nxt = NORM;
          emit      = 1'b1;
          emit_chr  = CH_NL;
        end
      end
      BLOCK: begin
        if (accept && (in == CH_STAR)) begin
          state_nxt = BSTAR;
        end
      end
      BSTAR: begin
        if (accept) begin
          if (in == CH_SLASH) begin
            state_nxt = NORM;
          end else if (in != CH_STAR) begin
            state_nxt = BLOCK;
          end
        end
      end
      default: begin
        state_nxt = NORM;
      end
    endcase
  end

  // State, pending character, output register and comment counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= NORM;
      pend        <= 8'd0;
      out         <= 8'd0;
      out_valid   <= 1'b0;
      comment_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      out_valid <= emit;
      if (emit) begin
        out <= emit_chr;
      end
      if (open_cmt) begin
        comment_cnt <= comment_cnt + 1'b1;
      end
    end
  end

endmodule
